// File: rtl/ripple_count_capture.sv
// Purpose: resynchronise a free-running 4-bit ripple count into Clock, reject mid-ripple codes,
//          and track rollovers and threshold hits.
// Latency: a held q_in value reaches count SYNC_STAGES+1 Clock edges after first capture.
// Backpressure: none; q_in must hold each code >= SYNC_STAGES+2 cycles, faster codes may be skipped.
//
// Ports:
//   Clock      system clock, all state on posedge
//   Reset      asynchronous active-high reset
//   q_in       ripple counter output, asynchronous to Clock
//   clear      synchronous clear of wraps and hit (wins over same-cycle wrap/hit)
//   threshold  compare value for hit
//   count      last accepted stable count
//   valid      high once any value has been accepted
//   wrap       one-cycle pulse when an accepted count is below the previous one
//   wraps      saturating rollover tally
//   hit        sticky: an accepted count equalled threshold
module ripple_count_capture #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WRAP_W      = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              clear,
  input  logic [WIDTH-1:0]  threshold,
  output logic [WIDTH-1:0]  count,
  output logic              valid,
  output logic              wrap,
  output logic [WRAP_W-1:0] wraps,
  output logic              hit
);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;

  logic accept;
  logic load;
  logic wrap_evt;
  logic hit_evt;

  assign s = sync[SYNC_STAGES-1];

  // Per-bit synchroniser chain; bits may land on different cycles, which the
  // stability filter below absorbs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= '0;
      end
      prev <= '0;
    end else begin
      sync[0] <= q_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= s;
    end
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: TRACK is only left through Reset
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = TRACK;
      TRACK:   state_nxt = TRACK;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output/decision logic. A code is trusted only after it has been seen on
  // two consecutive cycles at the synchroniser output.
  always_comb begin
    valid    = (state == TRACK);
    accept   = (s == prev);
    load     = accept && ((state == EMPTY) || (s != count));
    // The EMPTY->TRACK load never counts as a rollover.
    wrap_evt = (state == TRACK) && load && (s < count);
    hit_evt  = load && (s == threshold);
  end

  // Datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      wrap  <= 1'b0;
      wraps <= '0;
      hit   <= 1'b0;
    end else begin
      if (load) begin
        count <= s;
      end
      // wrap pulses regardless of clear or saturation
      wrap <= wrap_evt;
      if (clear) begin
        wraps <= '0;
        hit   <= 1'b0;
      end else begin
        if (wrap_evt && (wraps != {WRAP_W{1'b1}})) begin
          wraps <= wraps + 1'b1;
        end
        if (hit_evt) begin
          hit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
module tb_ripple_count_capture;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int WW = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [W-1:0]  q_in = '0;
  logic          clear = 1'b0;
  logic [W-1:0]  threshold = 4'd15;
  logic [W-1:0]  count;
  logic          valid;
  logic          wrap;
  logic [WW-1:0] wraps;
  logic          hit;

  int tests = 0;
  int fails = 0;
  int wrap_seen = 0;

  ripple_count_capture #(.WIDTH(W), .SYNC_STAGES(SS), .WRAP_W(WW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .q_in      (q_in),
    .clear     (clear),
    .threshold (threshold),
    .count     (count),
    .valid     (valid),
    .wrap      (wrap),
    .wraps     (wraps),
    .hit       (hit)
  );

  always #5 Clock = ~Clock;

  // Reference model: q_in seen through an SS-deep delay line, then the
  // acceptance / load / wrap / hit rules applied with plain arithmetic.
  int m_dly[$] = '{0, 0};
  int m_prev = 0, m_count = 0, m_wraps = 0;
  bit m_valid = 0, m_wrap = 0, m_hit = 0;
  int m_s;
  bit m_load, m_wrapnow;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_dly.delete();
      for (int i = 0; i < SS; i++) m_dly.push_back(0);
      m_prev = 0; m_count = 0; m_wraps = 0;
      m_valid = 0; m_wrap = 0; m_hit = 0;
    end else begin
      m_s       = m_dly[SS-1];
      m_load    = (m_s == m_prev) && (!m_valid || m_s != m_count);
      m_wrapnow = m_valid && m_load && (m_s < m_count);
      m_wrap    = m_wrapnow;
      if (clear) begin
        m_wraps = 0;
        m_hit   = 0;
      end else begin
        if (m_wrapnow && m_wraps < (1 << WW) - 1) m_wraps++;
        if (m_load && m_s == int'(threshold)) m_hit = 1;
      end
      if (m_load) begin
        m_count = m_s;
        m_valid = 1;
      end
      m_prev = m_s;
      m_dly.push_front(int'(q_in));
      void'(m_dly.pop_back());
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("model.count", 32'(count), 32'(m_count));
    chk("model.valid", 32'(valid), 32'(m_valid));
    chk("model.wrap",  32'(wrap),  32'(m_wrap));
    chk("model.wraps", 32'(wraps), 32'(m_wraps));
    chk("model.hit",   32'(hit),   32'(m_hit));
  endtask

  // One Clock edge, then compare on the following falling edge.
  task automatic step();
    @(negedge Clock);
    if (wrap === 1'b1) wrap_seen++;
    chk_model();
  endtask

  task automatic hold(input int v, input int n);
    q_in = W'(v);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  int snap;

  initial begin
    // ---- reset and first-capture latency ----
    Reset = 1'b1;
    q_in  = 4'd5;
    @(negedge Clock);
    @(negedge Clock);
    chk("reset.count", 32'(count), 0);
    chk("reset.valid", 32'(valid), 0);
    chk("reset.wraps", 32'(wraps), 0);
    chk("reset.hit",   32'(hit),   0);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lat.wrap", 32'(wrap), 0);
      chk("lat.hit",  32'(hit),  0);
    end
    chk("lat.count", 32'(count), 5);
    chk("lat.valid", 32'(valid), 1);

    // ---- glitch rejection ----
    hold(6, 6);
    chk("glitch.pre", 32'(count), 6);
    snap = m_wraps;
    wrap_seen = 0;
    hold(4, 1);
    hold(6, 6);
    chk("glitch.count", 32'(count), 6);
    chk("glitch.wrap",  32'(wrap_seen), 0);
    chk("glitch.wraps", 32'(wraps), 32'(snap));

    // ---- single rollover ----
    hold(0, 5);
    pulse_clear();
    wrap_seen = 0;
    for (int v = 1; v < 16; v++) hold(v, 5);
    chk("roll.count15", 32'(count), 15);
    chk("roll.nowrap",  32'(wrap_seen), 0);
    hold(0, 5);
    chk("roll.count0", 32'(count), 0);
    chk("roll.pulses", 32'(wrap_seen), 1);
    chk("roll.wraps",  32'(wraps), 1);

    // ---- saturation ----
    pulse_clear();
    for (int r = 0; r < 255; r++) begin
      hold(15, 4);
      hold(0, 4);
    end
    chk("sat.255", 32'(wraps), 255);
    wrap_seen = 0;
    hold(15, 4);
    hold(0, 4);
    chk("sat.pulse256", 32'(wrap_seen), 1);
    chk("sat.hold",     32'(wraps), 255);
    pulse_clear();
    chk("sat.clear", 32'(wraps), 0);

    // ---- hit vs clear priority ----
    threshold = 4'd9;
    q_in = 4'd9;
    step(); step(); step();
    clear = 1'b1;
    step();                 // the load edge for 9
    clear = 1'b0;
    chk("hit.prio.count", 32'(count), 9);
    chk("hit.prio.hit",   32'(hit), 0);
    hold(8, 5);
    hold(9, 5);
    chk("hit.set", 32'(hit), 1);
    hold(3, 5);
    chk("hit.sticky", 32'(hit), 1);
    pulse_clear();
    chk("hit.clear", 32'(hit), 0);

    // ---- reset mid-run ----
    pulse_clear();
    threshold = 4'd12;
    for (int r = 0; r < 3; r++) begin
      hold(15, 5);
      hold(0, 5);
    end
    hold(12, 5);
    chk("mid.count", 32'(count), 12);
    chk("mid.wraps", 32'(wraps), 3);
    chk("mid.hit",   32'(hit), 1);
    q_in  = 4'd2;
    Reset = 1'b1;
    #1;
    chk("mid.rst.count", 32'(count), 0);
    chk("mid.rst.valid", 32'(valid), 0);
    chk("mid.rst.wrap",  32'(wrap),  0);
    chk("mid.rst.wraps", 32'(wraps), 0);
    chk("mid.rst.hit",   32'(hit),   0);
    chk_model();
    step();
    step();
    Reset = 1'b0;
    wrap_seen = 0;
    for (int i = 0; i < 5; i++) step();
    chk("mid.post.count", 32'(count), 2);
    chk("mid.post.valid", 32'(valid), 1);
    chk("mid.post.wrap",  32'(wrap_seen), 0);
    chk("mid.post.wraps", 32'(wraps), 0);

    // ---- randomized run against the model ----
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) threshold = W'($urandom_range(0, 15));
      clear = ($urandom_range(0, 15) == 0);
      q_in  = W'($urandom_range(0, 15));
      step();
      clear = 1'b0;
      for (int i = $urandom_range(0, 5); i > 0; i--) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
